ahb_cipher_slave: RTL
=====================

Name: ahb_cipher_slave

Overview:
- Parametrised AHB-Lite slave front end for the Triple DES datapath; successor to the fixed 64-bit single-register slave controller.
- Holds mode and three key registers, buffers plaintext/ciphertext chunks in input and output FIFOs of configurable depth, and feeds the cipher core over valid/ready handshakes.
- Adds error responses on FIFO overflow/underflow or illegal reconfiguration, a status register, FIFO flush and a level interrupt.

Parameters:
- DATA_W, 64, bus data, key and chunk width.
- ADDR_W, 32, HADDR width.
- IN_DEPTH, 4, input FIFO entries (power of 2, 2..128).
- OUT_DEPTH, 4, output FIFO entries (power of 2, 2..128).
- IRQ_LEVEL, 1, output FIFO count at which irq asserts (1..OUT_DEPTH).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  address; HADDR[3:0] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HWRITE  in  1  1=write.
- HSIZE  in  3  ignored; full-width transfers only.
- HREADY  in  1  bus ready (previous transfer complete).
- HWDATA  in  DATA_W  write data (data phase).
- HRDATA  out  DATA_W  read data (data phase).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- mode  out  1  1=encrypt, 0=decrypt.
- key1, key2, key3  out  DATA_W each  user keys.
- core_in_data  out  DATA_W  head of input FIFO.
- core_in_valid  out  1  input FIFO not empty.
- core_in_ready  in  1  core accepts chunk.
- core_out_data  in  DATA_W  processed chunk.
- core_out_valid  in  1  core result valid.
- core_out_ready  out  1  output FIFO not full.
- core_busy  in  1  core has a chunk in flight.
- irq  out  1  output FIFO count >= IRQ_LEVEL.

Behaviour:
- Reset: mode=0, key1..3=0, both FIFOs empty, HRDATA=0, HREADYOUT=1, HRESP=0, irq=0, core_in_valid=0, core_out_ready=1.
- Address phase accepted when HSEL & HREADY & HTRANS[1].
  - Register offset, write flag and "bad" flag for the data phase on the next cycle.
  - Idle/unselected cycles give OKAY with zero wait states.
- Address map (HADDR[3:0]):
  - 0x0 mode (RW, bit 0).
  - 0x1..0x3 key1..key3 (RW).
  - 0x4 DATA_IN (W; push).
  - 0x8 DATA_OUT (R; pop).
  - 0x9 STATUS (R).
  - 0xA FLUSH (W; data ignored).
  - Other offsets: read 0, writes ignored, OKAY.
- Bad transfer (ERROR response), evaluated from registered state in the first data-phase cycle:
  - write DATA_IN with input FIFO full;
  - read DATA_OUT with output FIFO empty;
  - write 0x0..0x3 while core_busy or input FIFO non-empty.
- ERROR response is two cycles: HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1. A bad transfer has no side effect.
- OKAY transfers complete in one data-phase cycle; no wait states.
- Writes take HWDATA in the data phase and update at the closing edge. A DATA_IN push makes core_in_valid high on the next cycle if the FIFO was empty.
- DATA_OUT read: HRDATA = output FIFO head during the data phase; pop at the closing edge.
- STATUS read:
  - [0] in_empty, [1] in_full, [2] out_empty, [3] out_full;
  - [11:4] in_count, [19:12] out_count (zero-extended);
  - [20] mode, [21] core_busy; other bits 0.
- HRDATA is 0 outside read data phases.
- Core handshakes:
  - Input FIFO pops when core_in_valid & core_in_ready.
  - Output FIFO pushes when core_out_valid & core_out_ready.
  - Bus push and core pop in the same cycle are both honoured; count unchanged. Same for output.
- Flush clears both FIFOs at the closing edge. It overrides any same-cycle core push/pop; the chunk lost in that cycle is dropped.
- Pointers wrap modulo depth; counts are $clog2(DEPTH)+1 bits.
- irq is combinational from the registered output count.
- Async reset mid-transfer aborts it: outputs return to reset values immediately and any pending data phase is discarded.

Decomposition:
- Package cipher_ahb_pkg holds:
  - address offset constants;
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HRESP constants;
  - STATUS bit positions;
  - data-phase state enum (IDLE, OKAY, ERR1, ERR2).
- One sub-module, sync_fifo (parametrised WIDTH, DEPTH, synchronous flush), instantiated twice.

Test Plan:
- Reset, then write mode=1 and key1..3=0x1111…, 0x2222…, 0x3333… → key outputs and mode match; STATUS reads 0x100005 (in_empty, out_empty, mode set).
- Push 4 chunks 0x4444…–0x7777… with core_in_ready=0 → STATUS in_full=1, in_count=4; 5th push → two-cycle ERROR; FIFO contents unchanged.
- Raise core_in_ready → core_in_data presents 0x4444…, 0x5555…, 0x6666…, 0x7777… in order on consecutive cycles; core_in_valid drops after the 4th.
- Core returns 0xAAAA… with IRQ_LEVEL=1 → irq=1 the following cycle; DATA_OUT read returns 0xAAAA… with OKAY; irq clears.
- Read DATA_OUT when empty → ERROR, HRDATA=0.
- Key write with core_busy=1 → ERROR, key unchanged.
- Fill both FIFOs, write FLUSH, and pulse core_out_valid that cycle → both counts 0; the pulsed chunk is dropped.

Source files
------------

// File: rtl/cipher_ahb_pkg.sv
// Shared constants for the AHB-Lite cipher slave: register offsets, bus encodings,
// STATUS bit layout and the data-phase state type.
package cipher_ahb_pkg;

    localparam logic [3:0] OFF_MODE     = 4'h0;
    localparam logic [3:0] OFF_KEY1     = 4'h1;
    localparam logic [3:0] OFF_KEY2     = 4'h2;
    localparam logic [3:0] OFF_KEY3     = 4'h3;
    localparam logic [3:0] OFF_DATA_IN  = 4'h4;
    localparam logic [3:0] OFF_DATA_OUT = 4'h8;
    localparam logic [3:0] OFF_STATUS   = 4'h9;
    localparam logic [3:0] OFF_FLUSH    = 4'hA;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int STAT_IN_EMPTY   = 0;
    localparam int STAT_IN_FULL    = 1;
    localparam int STAT_OUT_EMPTY  = 2;
    localparam int STAT_OUT_FULL   = 3;
    localparam int STAT_IN_CNT_LSB  = 4;
    localparam int STAT_OUT_CNT_LSB = 12;
    localparam int STAT_MODE       = 20;
    localparam int STAT_BUSY       = 21;

    typedef enum logic [1:0] {
        DP_IDLE = 2'b00,
        DP_OKAY = 2'b01,
        DP_ERR1 = 2'b10,
        DP_ERR2 = 2'b11
    } dp_state_e;

endpackage

// File: rtl/ahb_cipher_slave_sync_fifo.sv
// Synchronous FIFO with registered storage and a flush that overrides any
// push/pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty     = (count_q == {CW{1'b0}});
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ahb_cipher_slave.sv
// AHB-Lite slave front end for the Triple DES core: mode/key registers,
// input/output chunk FIFOs, status, flush and a level interrupt.
module ahb_cipher_slave
    import cipher_ahb_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              mode,
    output logic [DATA_W-1:0] key1,
    output logic [DATA_W-1:0] key2,
    output logic [DATA_W-1:0] key3,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    input  logic [DATA_W-1:0] core_out_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic              core_busy,
    output logic              irq
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    dp_state_e         dp_state_q, dp_state_d, dp_phase_s;
    logic [3:0]        dp_addr_q, dp_addr_d;
    logic              dp_write_q, dp_write_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;

    logic              accept_s, active_s, bad_s, ok_xfer_s;
    logic              bus_push_s, bus_pop_s, flush_s;
    logic              in_pop_s, out_push_s;
    logic [DATA_W-1:0] out_head_s, status_s, rdata_s;
    logic [IN_CW-1:0]  in_count_s;
    logic [OUT_CW-1:0] out_count_s;
    logic              in_empty_s, in_full_s, out_empty_s, out_full_s;
    logic [7:0]        in_cnt8_s, out_cnt8_s;
    logic              unused_s;

    assign unused_s = ^{HSIZE, HADDR[ADDR_W-1:4], HTRANS[0]};

    assign accept_s  = HSEL && HREADY && HTRANS[1];
    assign active_s  = (dp_state_q == DP_OKAY);

    // A transfer is rejected from the state seen in its first data-phase cycle
    always_comb begin
        bad_s = 1'b0;
        if (dp_write_q) begin
            if (dp_addr_q == OFF_DATA_IN) begin
                bad_s = in_full_s;
            end else if (dp_addr_q <= OFF_KEY3) begin
                bad_s = core_busy || !in_empty_s;
            end else begin
                bad_s = 1'b0;
            end
        end else begin
            bad_s = (dp_addr_q == OFF_DATA_OUT) && out_empty_s;
        end
    end

    assign ok_xfer_s  = active_s && !bad_s;
    assign dp_phase_s = (active_s && bad_s) ? DP_ERR1 : dp_state_q;
    assign HREADYOUT  = (dp_phase_s != DP_ERR1);
    assign HRESP      = (dp_phase_s == DP_ERR1 || dp_phase_s == DP_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    assign bus_push_s = ok_xfer_s && dp_write_q && (dp_addr_q == OFF_DATA_IN);
    assign bus_pop_s  = ok_xfer_s && !dp_write_q && (dp_addr_q == OFF_DATA_OUT);
    assign flush_s    = ok_xfer_s && dp_write_q && (dp_addr_q == OFF_FLUSH);

    assign core_in_valid  = !in_empty_s;
    assign core_out_ready = !out_full_s;
    assign in_pop_s       = core_in_valid && core_in_ready;
    assign out_push_s     = core_out_valid && core_out_ready;
    assign irq            = (out_count_s >= OUT_CW'(IRQ_LEVEL));

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .flush     (flush_s),
        .push      (bus_push_s),
        .push_data (HWDATA),
        .pop       (in_pop_s),
        .head_data (core_in_data),
        .count     (in_count_s),
        .empty     (in_empty_s),
        .full      (in_full_s)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .flush     (flush_s),
        .push      (out_push_s),
        .push_data (core_out_data),
        .pop       (bus_pop_s),
        .head_data (out_head_s),
        .count     (out_count_s),
        .empty     (out_empty_s),
        .full      (out_full_s)
    );

    assign in_cnt8_s  = 8'(in_count_s);
    assign out_cnt8_s = 8'(out_count_s);

    // STATUS word assembly
    always_comb begin
        status_s = {DATA_W{1'b0}};
        status_s[STAT_IN_EMPTY]  = in_empty_s;
        status_s[STAT_IN_FULL]   = in_full_s;
        status_s[STAT_OUT_EMPTY] = out_empty_s;
        status_s[STAT_OUT_FULL]  = out_full_s;
        status_s[STAT_IN_CNT_LSB +: 8]  = in_cnt8_s;
        status_s[STAT_OUT_CNT_LSB +: 8] = out_cnt8_s;
        status_s[STAT_MODE] = mode_q;
        status_s[STAT_BUSY] = core_busy;
    end

    // Read data mux, zero outside a successful read data phase
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (ok_xfer_s && !dp_write_q) begin
            case (dp_addr_q)
                OFF_MODE:     rdata_s = {{(DATA_W-1){1'b0}}, mode_q};
                OFF_KEY1:     rdata_s = key1_q;
                OFF_KEY2:     rdata_s = key2_q;
                OFF_KEY3:     rdata_s = key3_q;
                OFF_DATA_OUT: rdata_s = out_head_s;
                OFF_STATUS:   rdata_s = status_s;
                default:      rdata_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

    assign HRDATA = rdata_s;

    // Configuration register updates at the closing edge of a good write
    always_comb begin
        mode_d = mode_q;
        key1_d = key1_q;
        key2_d = key2_q;
        key3_d = key3_q;
        if (ok_xfer_s && dp_write_q) begin
            case (dp_addr_q)
                OFF_MODE: mode_d = HWDATA[0];
                OFF_KEY1: key1_d = HWDATA;
                OFF_KEY2: key2_d = HWDATA;
                OFF_KEY3: key3_d = HWDATA;
                default:  mode_d = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Data-phase sequencing; an error holds the bus for one extra cycle
    always_comb begin
        dp_addr_d  = dp_addr_q;
        dp_write_d = dp_write_q;
        dp_state_d = DP_IDLE;
        if (dp_phase_s == DP_ERR1) begin
            dp_state_d = DP_ERR2;
        end else if (accept_s) begin
            dp_state_d = DP_OKAY;
            dp_addr_d  = HADDR[3:0];
            dp_write_d = HWRITE;
        end else begin
            dp_state_d = DP_IDLE;
        end
    end

    // Slave state registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_state_q <= DP_IDLE;
            dp_addr_q  <= 4'h0;
            dp_write_q <= 1'b0;
            mode_q     <= 1'b0;
            key1_q     <= {DATA_W{1'b0}};
            key2_q     <= {DATA_W{1'b0}};
            key3_q     <= {DATA_W{1'b0}};
        end else begin
            dp_state_q <= dp_state_d;
            dp_addr_q  <= dp_addr_d;
            dp_write_q <= dp_write_d;
            mode_q     <= mode_d;
            key1_q     <= key1_d;
            key2_q     <= key2_d;
            key3_q     <= key3_d;
        end
    end

    assign mode = mode_q;
    assign key1 = key1_q;
    assign key2 = key2_q;
    assign key3 = key3_q;

endmodule
